// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for a registered ALU: accepts one operation per handshake,
// waits out the ALU latency, captures the result and holds it on a valid/ready port.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 16,
    parameter int FUN_W   = 4,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [FUN_W-1:0] cmd_fun,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FUN_W-1:0] alu_fun,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c_out,
    input  logic [3:0]       alu_flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_c_out,
    output logic [3:0]       res_flags,
    output logic [FUN_W-1:0] res_fun,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int LAT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q,     state_d;
    logic [LAT_W-1:0] lat_cnt_q,   lat_cnt_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    logic [FUN_W-1:0] alu_fun_q,   alu_fun_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_c_out_q, res_c_out_d;
    logic [3:0]       res_flags_q, res_flags_d;
    logic [FUN_W-1:0] res_fun_q,   res_fun_d;
    logic             res_err_q,   res_err_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;
    logic             multi_flag;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_flag = (alu_flags & (alu_flags - 4'd1)) != 4'd0;

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_c_out_d = res_c_out_q;
        res_flags_d = res_flags_q;
        res_fun_d   = res_fun_q;
        res_err_d   = res_err_q;
        op_count_d  = op_count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_fun_d = cmd_fun;
                    res_fun_d = cmd_fun;
                    lat_cnt_d = LAT_W'(ALU_LAT);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end else begin
                    res_data_d  = alu_out;
                    res_c_out_d = alu_c_out;
                    res_flags_d = alu_flags;
                    res_err_d   = multi_flag;
                    res_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_c_out_q <= 1'b0;
            res_flags_q <= '0;
            res_fun_q   <= '0;
            res_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_c_out_q <= res_c_out_d;
            res_flags_q <= res_flags_d;
            res_fun_q   <= res_fun_d;
            res_err_q   <= res_err_d;
            op_count_q  <= op_count_d;
        end
    end

    // Ready is gated by rst so nothing can be accepted while reset is held.
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_c_out = res_c_out_q;
    assign res_flags = res_flags_q;
    assign res_fun   = res_fun_q;
    assign res_err   = res_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-cycle registered ALU model;
// a 5-bit op counter keeps the wrap case short.
module tb_alu_cmd_sequencer;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [15:0]   cmd_a = '0;
    logic [15:0]   cmd_b = '0;
    logic [3:0]    cmd_fun = '0;
    logic [15:0]   alu_a, alu_b;
    logic [3:0]    alu_fun;
    logic [15:0]   alu_out = '0;
    logic          alu_c_out = 1'b0;
    logic [3:0]    alu_flags = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [15:0]   res_data;
    logic          res_c_out;
    logic [3:0]    res_flags;
    logic [3:0]    res_fun;
    logic          res_err;
    logic          busy;
    logic [CW-1:0] op_count;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          force_flags = 1'b0;

    alu_cmd_sequencer #(.WIDTH(16), .FUN_W(4), .ALU_LAT(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_out(alu_out), .alu_c_out(alu_c_out), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_c_out(res_c_out), .res_flags(res_flags),
        .res_fun(res_fun), .res_err(res_err), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: flags are {arith, logic, cmp, shift}.
    logic [15:0] m_res;
    logic        m_c;
    logic [3:0]  m_flags;
    always_comb begin
        m_res   = '0;
        m_c     = 1'b0;
        m_flags = '0;
        case (alu_fun)
            4'd0: begin {m_c, m_res} = {1'b0, alu_a} + {1'b0, alu_b}; m_flags = 4'b1000; end
            4'd1: begin {m_c, m_res} = {1'b0, alu_a} - {1'b0, alu_b}; m_flags = 4'b1000; end
            4'd2: begin m_res = alu_a & alu_b; m_flags = 4'b0100; end
            4'd3: begin m_res = alu_a | alu_b; m_flags = 4'b0100; end
            4'd4: begin m_res = alu_a ^ alu_b; m_flags = 4'b0100; end
            4'd5: begin m_res = ~alu_a;        m_flags = 4'b0100; end
            4'd6: begin m_res = {15'd0, alu_a == alu_b}; m_flags = 4'b0010; end
            4'd7: begin m_res = {15'd0, alu_a < alu_b};  m_flags = 4'b0010; end
            4'd8: begin m_res = alu_a << 1; m_c = alu_a[15]; m_flags = 4'b0001; end
            4'd9: begin m_res = alu_a >> 1; m_c = alu_a[0];  m_flags = 4'b0001; end
            default: ;
        endcase
        if (force_flags) m_flags = 4'b0110;
    end

    always_ff @(posedge clk) begin
        alu_out   <= m_res;
        alu_c_out <= m_c;
        alu_flags <= m_flags;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic [15:0] data;
        logic        c;
        logic [3:0]  flags;
        logic        err;
    } vec_t;

    vec_t vecs [22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready before send", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = fun;
        tick();
        cmd_valid = 1'b0;
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        cmd_fun   = 4'($urandom);
    endtask

    task automatic wait_res(input string tag);
        int lat = 0;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 32'd2);
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        exp_cnt   = exp_cnt + 1'b1;
        chk({tag, " res_valid drop"}, {31'd0, res_valid}, 32'd0);
        chk({tag, " op_count"}, {27'd0, op_count}, {27'd0, exp_cnt});
    endtask

    task automatic check_res(input string tag, input vec_t v);
        chk({tag, " res_data"},  {16'd0, res_data},  {16'd0, v.data});
        chk({tag, " res_c_out"}, {31'd0, res_c_out}, {31'd0, v.c});
        chk({tag, " res_flags"}, {28'd0, res_flags}, {28'd0, v.flags});
        chk({tag, " res_fun"},   {28'd0, res_fun},   {28'd0, v.fun});
        chk({tag, " res_err"},   {31'd0, res_err},   {31'd0, v.err});
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        send(v.a, v.b, v.fun);
        wait_res(tag);
        check_res(tag, v);
        $display("%s: a=%h b=%h fun=%0d -> data=%h c=%0b flags=%b err=%0b",
                 tag, v.a, v.b, v.fun, res_data, res_c_out, res_flags, res_err);
        consume(tag);
    endtask

    initial begin
        vec_t tmp;
        vecs[0]  = '{16'd20,    16'd1,  4'd0, 16'd21,    1'b0, 4'b1000, 1'b0};
        vecs[0]  = '{16'd20,    16'd15, 4'd0, 16'd35,    1'b0, 4'b1000, 1'b0};
        vecs[1]  = '{16'hFFFF,  16'd1,  4'd0, 16'h0000,  1'b1, 4'b1000, 1'b0};
        vecs[2]  = '{16'd20,    16'd15, 4'd0, 16'd35,    1'b0, 4'b1000, 1'b0};
        vecs[3]  = '{16'd20,    16'd15, 4'd1, 16'd5,     1'b0, 4'b1000, 1'b0};
        vecs[4]  = '{16'd20,    16'd15, 4'd2, 16'd4,     1'b0, 4'b0100, 1'b0};
        vecs[5]  = '{16'd20,    16'd15, 4'd3, 16'd31,    1'b0, 4'b0100, 1'b0};
        vecs[6]  = '{16'd20,    16'd15, 4'd4, 16'd27,    1'b0, 4'b0100, 1'b0};
        vecs[7]  = '{16'd20,    16'd15, 4'd5, 16'hFFEB,  1'b0, 4'b0100, 1'b0};
        vecs[8]  = '{16'd20,    16'd15, 4'd6, 16'd0,     1'b0, 4'b0010, 1'b0};
        vecs[9]  = '{16'd20,    16'd15, 4'd7, 16'd0,     1'b0, 4'b0010, 1'b0};
        vecs[10] = '{16'd20,    16'd15, 4'd8, 16'd40,    1'b0, 4'b0001, 1'b0};
        vecs[11] = '{16'd20,    16'd15, 4'd9, 16'd10,    1'b0, 4'b0001, 1'b0};
        vecs[12] = '{16'd20,    16'd15, 4'd10, 16'd0,    1'b0, 4'b0000, 1'b0};
        vecs[13] = '{16'd20,    16'd15, 4'd11, 16'd0,    1'b0, 4'b0000, 1'b0};
        vecs[14] = '{16'd20,    16'd15, 4'd12, 16'd0,    1'b0, 4'b0000, 1'b0};
        vecs[15] = '{16'd20,    16'd15, 4'd13, 16'd0,    1'b0, 4'b0000, 1'b0};
        vecs[16] = '{16'd20,    16'd15, 4'd14, 16'd0,    1'b0, 4'b0000, 1'b0};
        vecs[17] = '{16'd20,    16'd15, 4'd15, 16'd0,    1'b0, 4'b0000, 1'b0};
        vecs[18] = '{16'd3,     16'd5,  4'd1, 16'hFFFE,  1'b1, 4'b1000, 1'b0};
        vecs[19] = '{16'h8001,  16'd0,  4'd8, 16'h0002,  1'b1, 4'b0001, 1'b0};
        vecs[20] = '{16'h00FF,  16'h0F0F, 4'd4, 16'h0FF0, 1'b0, 4'b0100, 1'b0};
        vecs[21] = '{16'd7,     16'd7,  4'd6, 16'd1,     1'b0, 4'b0010, 1'b0};

        // Power-on reset: outputs must clear as soon as rst rises.
        #2 rst = 1'b1;
        #1;
        chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("reset busy",      {31'd0, busy},      32'd0);
        chk("reset res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset op_count",  {27'd0, op_count},  32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post-reset cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Make the outputs nonzero, then reset in the middle of WAIT.
        run_vec("pre-reset op", vecs[1]);
        send(16'h1234, 16'h5678, 4'd3);
        chk("mid-wait busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst alu_a",     {16'd0, alu_a},     32'd0);
        chk("async rst alu_b",     {16'd0, alu_b},     32'd0);
        chk("async rst alu_fun",   {28'd0, alu_fun},   32'd0);
        chk("async rst res_data",  {16'd0, res_data},  32'd0);
        chk("async rst res_c_out", {31'd0, res_c_out}, 32'd0);
        chk("async rst res_flags", {28'd0, res_flags}, 32'd0);
        chk("async rst res_fun",   {28'd0, res_fun},   32'd0);
        chk("async rst op_count",  {27'd0, op_count},  32'd0);
        chk("async rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("async rst busy",      {31'd0, busy},      32'd0);
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        tick();
        chk("cmd_ready after release", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("no stale res_valid", {31'd0, res_valid}, 32'd0);
            tick();
        end
        $display("reset mid-WAIT: op_count=%0d res_valid=%0b", op_count, res_valid);

        // Directed vectors, including the back-to-back function sweep.
        for (int i = 0; i < 22; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end
        chk("op_count after sweep", {27'd0, op_count}, 32'd22);

        // Backpressure: result held, second command not accepted until consumed.
        send(16'd20, 16'd15, 4'd2);
        wait_res("bp");
        cmd_valid = 1'b1;
        cmd_a     = 16'd7;
        cmd_b     = 16'd8;
        cmd_fun   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp res_data",  {16'd0, res_data},  32'd4);
            chk("bp res_fun",   {28'd0, res_fun},   32'd2);
            chk("bp cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp alu_a held", {16'd0, alu_a},    32'd20);
        end
        $display("bp: held data=%h fun=%0d for 5 cycles", res_data, res_fun);
        consume("bp");
        chk("bp ready after consume", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("bp pending accepted", {31'd0, busy}, 32'd1);
        wait_res("bp2");
        tmp = '{16'd7, 16'd8, 4'd0, 16'd15, 1'b0, 4'b1000, 1'b0};
        check_res("bp2", tmp);
        $display("bp2: a=7 b=8 fun=0 -> data=%h", res_data);
        consume("bp2");

        // Two flags at once must raise res_err.
        force_flags = 1'b1;
        tmp = '{16'd20, 16'd15, 4'd0, 16'd35, 1'b0, 4'b0110, 1'b1};
        run_vec("multi-flag", tmp);
        force_flags = 1'b0;

        // Counter wrap from all-ones back to zero.
        for (int g = 0; g < 40 && exp_cnt != {CW{1'b1}}; g++) begin
            run_vec("fill", vecs[0]);
        end
        chk("op_count at max", {27'd0, op_count}, 32'd31);
        run_vec("wrap", vecs[0]);
        chk("op_count wrapped", {27'd0, op_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
